// File: rtl/operand_stage.sv
// Operand fetch / writeback stage: decodes one instruction, presents operands to an
// external combinational ALU, then writes the result back three cycles per instruction.
module operand_stage #(
    parameter int NUM_REGS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [4:0]  alu_opcode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        zflag,
    output logic        illegal,
    output logic [15:0] retire_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [3:0] NREGS    = 4'(NUM_REGS);
    localparam logic [4:0] OP_STORE = 5'b00010;

    state_t      state;
    state_t      state_nx;
    logic        handshake;

    logic [4:0]  f_op;
    logic [2:0]  f_rd;
    logic [2:0]  f_rs1;
    logic [2:0]  f_rs2;
    logic        f_use_imm;
    logic [31:0] f_imm_sx;
    logic        unused_bits;

    logic [31:0] regs [0:7];
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic [4:0]  op_q;
    logic [2:0]  rd_q;
    logic [31:0] res_q;
    logic        zero_q;
    logic        op_legal;
    logic        rd_writable;

    assign f_op        = in_instr[31:27];
    assign f_rd        = in_instr[26:24];
    assign f_rs1       = in_instr[23:21];
    assign f_rs2       = in_instr[20:18];
    assign f_use_imm   = in_instr[17];
    assign f_imm_sx    = {{16{in_instr[15]}}, in_instr[15:0]};
    assign unused_bits = in_instr[16];

    // Handshake rules: a transfer happens at a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE and does not depend on in_valid.
    assign handshake = in_valid && in_ready;
    assign state_dbg = state;

    assign op_legal    = (op_q >= 5'b00001) && (op_q <= 5'b01010);
    assign rd_writable = (rd_q != 3'd0) && ({1'b0, rd_q} < NREGS);

    // R0 and registers beyond the configured depth always read as zero.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (f_rs1 != 3'd0 && {1'b0, f_rs1} < NREGS) rs1_val = regs[f_rs1];
        if (f_rs2 != 3'd0 && {1'b0, f_rs2} < NREGS) rs2_val = regs[f_rs2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = EXEC;
            end
            EXEC:    state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode   <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            zflag        <= 1'b0;
            illegal      <= 1'b0;
            retire_count <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        op_q       <= f_op;
                        rd_q       <= f_rd;
                        alu_opcode <= f_op;
                        alu_a      <= rs1_val;
                        alu_b      <= f_use_imm ? f_imm_sx : rs2_val;
                    end
                end
                EXEC: begin
                    res_q  <= alu_result;
                    zero_q <= alu_zero;
                end
                WB: begin
                    retire_count <= retire_count + 16'd1;
                    if (op_legal) begin
                        zflag <= zero_q;
                        if (op_q != OP_STORE && rd_writable) regs[rd_q] <= res_q;
                    end else begin
                        illegal <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: table of single instructions, back-to-back issue,
// retire counter wrap and reset abort in EXEC/WB, against a small ALU model.
module tb_operand_stage;

    localparam int NUM_REGS = 6;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic        z;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        zflag;
    logic        illegal;
    logic [15:0] retire_count;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [16];
    vec_t bb   [3];

    operand_stage #(.NUM_REGS(NUM_REGS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .zflag        (zflag),
        .illegal      (illegal),
        .retire_count (retire_count),
        .state_dbg    (state_dbg)
    );

    // ALU model: SUB/AND/OR/XOR decoded, everything else adds.
    always_comb begin
        case (alu_opcode)
            5'd4:    alu_result = alu_a - alu_b;
            5'd5:    alu_result = alu_a & alu_b;
            5'd6:    alu_result = alu_a | alu_b;
            5'd7:    alu_result = alu_a ^ alu_b;
            default: alu_result = alu_a + alu_b;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic use_imm, input logic [15:0] imm);
        return {op, rd, rs1, rs2, use_imm, 1'b0, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts just after a falling edge in IDLE; ends just after the falling edge following WB.
    task automatic run_vec(input vec_t v, input string tag);
        in_valid = 1'b1;
        in_instr = v.instr;
        @(posedge clk); @(negedge clk);
        check({tag, " exec_ready"}, 32'(in_ready), 32'd0);
        check({tag, " exec_state"}, 32'(state_dbg), 32'd1);
        check({tag, " alu_opcode"}, 32'(alu_opcode), 32'(v.instr[31:27]));
        check({tag, " alu_a"}, alu_a, v.a);
        check({tag, " alu_b"}, alu_b, v.b);
        check({tag, " illegal_low"}, 32'(illegal), 32'd0);
        in_valid = 1'b0;
        in_instr = $urandom;
        @(posedge clk); @(negedge clk);
        check({tag, " wb_ready"}, 32'(in_ready), 32'd0);
        check({tag, " wb_state"}, 32'(state_dbg), 32'd2);
        @(posedge clk); @(negedge clk);
        check({tag, " idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, " zflag"}, 32'(zflag), 32'(v.z));
        check({tag, " illegal"}, 32'(illegal), 32'(v.ill));
        check({tag, " retire_count"}, 32'(retire_count), 32'(v.cnt));
    endtask

    task automatic abort_at(input logic [31:0] instr, input int phase, input string tag);
        in_valid = 1'b1;
        in_instr = instr;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        if (phase == 2) begin
            @(posedge clk); @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check({tag, " rst_ready"}, 32'(in_ready), 32'd1);
        check({tag, " rst_state"}, 32'(state_dbg), 32'd0);
        check({tag, " rst_count"}, 32'(retire_count), 32'd0);
        check({tag, " rst_alu_a"}, alu_a, 32'd0);
        check({tag, " rst_alu_b"}, alu_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int idx;
        logic hs;

        // Expected values worked out by hand; NUM_REGS=6 so rd 6/7 are discarded.
        vecs[0]  = '{mk(5'd3,  3'd1, 3'd0, 3'd0, 1'b1, 16'h0005), 32'd0,        32'd5,        1'b0, 1'b0, 16'd1};
        vecs[1]  = '{mk(5'd4,  3'd2, 3'd1, 3'd1, 1'b0, 16'h0000), 32'd5,        32'd5,        1'b1, 1'b0, 16'd2};
        vecs[2]  = '{mk(5'd3,  3'd3, 3'd1, 3'd0, 1'b1, 16'hFFFF), 32'd5,        32'hFFFFFFFF, 1'b0, 1'b0, 16'd3};
        vecs[3]  = '{mk(5'd3,  3'd4, 3'd3, 3'd1, 1'b0, 16'h0000), 32'd4,        32'd5,        1'b0, 1'b0, 16'd4};
        vecs[4]  = '{mk(5'd2,  3'd5, 3'd2, 3'd2, 1'b0, 16'h0000), 32'd0,        32'd0,        1'b1, 1'b0, 16'd5};
        vecs[5]  = '{mk(5'd3,  3'd6, 3'd5, 3'd0, 1'b1, 16'h0001), 32'd0,        32'd1,        1'b0, 1'b0, 16'd6};
        vecs[6]  = '{mk(5'd31, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0000), 32'd0,        32'd0,        1'b0, 1'b1, 16'd7};
        vecs[7]  = '{mk(5'd3,  3'd5, 3'd1, 3'd6, 1'b0, 16'h0000), 32'd5,        32'd0,        1'b0, 1'b0, 16'd8};
        vecs[8]  = '{mk(5'd3,  3'd0, 3'd1, 3'd0, 1'b1, 16'h0003), 32'd5,        32'd3,        1'b0, 1'b0, 16'd9};
        vecs[9]  = '{mk(5'd3,  3'd1, 3'd0, 3'd7, 1'b0, 16'h0000), 32'd0,        32'd0,        1'b1, 1'b0, 16'd10};
        vecs[10] = '{mk(5'd6,  3'd2, 3'd5, 3'd0, 1'b1, 16'h8000), 32'd5,        32'hFFFF8000, 1'b0, 1'b0, 16'd11};
        vecs[11] = '{mk(5'd7,  3'd3, 3'd2, 3'd2, 1'b0, 16'h0000), 32'hFFFF8005, 32'hFFFF8005, 1'b1, 1'b0, 16'd12};
        vecs[12] = '{mk(5'd11, 3'd4, 3'd4, 3'd0, 1'b0, 16'h0000), 32'd9,        32'd0,        1'b1, 1'b1, 16'd13};
        vecs[13] = '{mk(5'd10, 3'd5, 3'd4, 3'd0, 1'b1, 16'h0000), 32'd9,        32'd0,        1'b0, 1'b0, 16'd14};
        vecs[14] = '{mk(5'd0,  3'd4, 3'd3, 3'd0, 1'b0, 16'h0000), 32'd0,        32'd0,        1'b0, 1'b1, 16'd15};
        vecs[15] = '{mk(5'd1,  3'd5, 3'd4, 3'd5, 1'b0, 16'h0000), 32'd9,        32'd9,        1'b0, 1'b0, 16'd16};

        bb[0] = '{mk(5'd3, 3'd1, 3'd5, 3'd0, 1'b1, 16'h0001), 32'h12, 32'd1,  1'b0, 1'b0, 16'd17};
        bb[1] = '{mk(5'd3, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001), 32'h13, 32'd1,  1'b0, 1'b0, 16'd18};
        bb[2] = '{mk(5'd4, 3'd3, 3'd2, 3'd1, 1'b0, 16'h0000), 32'h14, 32'h13, 1'b0, 1'b0, 16'd19};

        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset state", 32'(state_dbg), 32'd0);
        check("reset alu_opcode", 32'(alu_opcode), 32'd0);
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_b", alu_b, 32'd0);
        check("reset zflag", 32'(zflag), 32'd0);
        check("reset illegal", 32'(illegal), 32'd0);
        check("reset retire_count", 32'(retire_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle with no handshake: outputs hold.
        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            if (i == 4) begin
                @(posedge clk); @(negedge clk);
                check("idle_hold alu_a", alu_a, 32'd0);
                check("idle_hold state", 32'(state_dbg), 32'd0);
            end
        end

        // Back-to-back issue with in_valid held high.
        idx = 0;
        in_valid = 1'b1;
        in_instr = bb[0].instr;
        for (int c = 0; c < 9; c++) begin
            check($sformatf("b2b ready c%0d", c), 32'(in_ready), (c % 3 == 0) ? 32'd1 : 32'd0);
            hs = in_valid && in_ready;
            @(posedge clk); @(negedge clk);
            if (hs) begin
                check($sformatf("b2b alu_a i%0d", idx), alu_a, bb[idx].a);
                check($sformatf("b2b alu_b i%0d", idx), alu_b, bb[idx].b);
                idx++;
                if (idx < 3) in_instr = bb[idx].instr;
                else begin
                    in_valid = 1'b0;
                    in_instr = $urandom;
                end
            end
        end
        check("b2b handshakes", 32'(idx), 32'd3);
        check("b2b retire_count", 32'(retire_count), 32'd19);
        check("b2b zflag", 32'(zflag), 32'd0);

        // Counter wrap: preload all-ones while idle, then retire one more.
        force dut.retire_count = 16'hFFFF;
        @(posedge clk); @(negedge clk);
        release dut.retire_count;
        run_vec('{mk(5'd3, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0000), 32'h13, 32'd0, 1'b0, 1'b0, 16'd0}, "wrap");

        // Reset aborts in EXEC and in WB; neither aborted write may land.
        abort_at(mk(5'd3, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0007), 1, "abort_exec");
        abort_at(mk(5'd3, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0009), 2, "abort_wb");
        run_vec('{mk(5'd3, 3'd4, 3'd3, 3'd2, 1'b0, 16'h0000), 32'd0, 32'd0, 1'b1, 1'b0, 16'd1}, "post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
